// File: rtl/color_sense_pkg.sv
// Shared types and constants for the TCS3200 colour scan: FSM states,
// filter select codes, default timing and the counter width.
package color_sense_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_ZERO = 10'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 10'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = 10'd1023;

  localparam int SETTLE_CYC_DEF = 50000;
  localparam int GATE_CYC_DEF   = 500000;

  // {S2,S3} photodiode filter selects
  localparam logic [1:0] RED_S2S3   = 2'b00;
  localparam logic [1:0] BLUE_S2S3  = 2'b01;
  localparam logic [1:0] GREEN_S2S3 = 2'b11;

  // Declaration order is the scan order; the scheduler steps by +1.
  typedef enum logic [3:0] {
    IDLE,
    GRANT,
    SETTLE_R,
    GATE_R,
    SETTLE_B,
    GATE_B,
    SETTLE_G,
    GATE_G,
    DONE
  } state_e;

  function automatic logic [1:0] filter_code(input state_e st);
    logic [1:0] code;
    case (st)
      SETTLE_B, GATE_B:       code = BLUE_S2S3;
      SETTLE_G, GATE_G, DONE: code = GREEN_S2S3;
      default:                code = RED_S2S3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/out_edge_counter.sv
// Synchronises the sensor OUT frequency and counts its rising edges,
// saturating at the counter maximum.
module out_edge_counter
  import color_sense_pkg::*;
(
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             sensor_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  logic [1:0]       sync_q;
  logic             prev_q;
  logic [CNT_W-1:0] count_q;
  logic             rise_s;

  assign rise_s = sync_q[1] & ~prev_q;

  // Two-flop synchroniser, edge-detect history and the saturating counter.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      prev_q  <= 1'b0;
      count_q <= CNT_ZERO;
    end else begin
      sync_q <= {sync_q[0], sensor_i};
      prev_q <= sync_q[1];
      if (clr_i) begin
        count_q <= CNT_ZERO;
      end else if (en_i && rise_s && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_ONE;
      end else begin
        count_q <= count_q;
      end
    end
  end

  assign count_o = count_q;
  assign sat_o   = (count_q == CNT_MAX);

endmodule

// File: rtl/color_scan_scheduler.sv
// Round-robin scheduler that runs a red/blue/green TCS3200 scan for one of
// two requesters and latches the three pulse counts.
module color_scan_scheduler
  import color_sense_pkg::*;
#(
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int GATE_CYC   = GATE_CYC_DEF
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  input  logic             sensor_out,
  output logic             S0,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] blue,
  output logic [CNT_W-1:0] green,
  output logic [2:0]       sat,
  output logic             done,
  output logic             busy
);

  localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_ZERO    = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE     = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYC - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rr_q, rr_d;
  logic             s0_q, s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] red_q, blue_q, green_q;
  logic [2:0]       sat_q;
  logic             done_q, busy_q;

  logic [CNT_W-1:0] cnt_s;
  logic             cnt_sat_s, cnt_clr_s, cnt_en_s;
  logic             phase_last_s, abort_s, latch_s;

  out_edge_counter u_cnt (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .sensor_i (sensor_out),
    .clr_i    (cnt_clr_s),
    .en_i     (cnt_en_s),
    .count_o  (cnt_s),
    .sat_o    (cnt_sat_s)
  );

  // Phase decode, abort detection, arbitration and next-state selection.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    cnt_clr_s    = 1'b0;
    cnt_en_s     = 1'b0;
    phase_last_s = 1'b0;
    abort_s      = 1'b0;

    case (state_q)
      GRANT: abort_s = ((gnt_q & req) == 2'b00);
      SETTLE_R, SETTLE_B, SETTLE_G: begin
        cnt_clr_s    = 1'b1;
        phase_last_s = (tmr_q == SETTLE_LAST);
        abort_s      = ((gnt_q & req) == 2'b00);
      end
      GATE_R, GATE_B, GATE_G: begin
        cnt_en_s     = 1'b1;
        phase_last_s = (tmr_q == GATE_LAST);
        abort_s      = ((gnt_q & req) == 2'b00);
      end
      default: abort_s = 1'b0;
    endcase

    // An aborted gate never completed, so it must not overwrite its colour.
    latch_s = cnt_en_s & phase_last_s & ~abort_s;

    if (abort_s) begin
      state_d = IDLE;
      gnt_d   = 2'b00;
      tmr_d   = TMR_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != 2'b00) begin
            state_d = GRANT;
            tmr_d   = TMR_ZERO;
            if (req == 2'b11) begin
              gnt_d = rr_q ? 2'b10 : 2'b01;
            end else begin
              gnt_d = req;
            end
            rr_d = gnt_d[0];
          end else begin
            state_d = IDLE;
            gnt_d   = 2'b00;
          end
        end
        GRANT: begin
          state_d = SETTLE_R;
          tmr_d   = TMR_ZERO;
        end
        SETTLE_R, GATE_R, SETTLE_B, GATE_B, SETTLE_G, GATE_G: begin
          if (phase_last_s) begin
            state_d = state_e'(state_q + 4'd1);
            tmr_d   = TMR_ZERO;
          end else begin
            tmr_d = tmr_q + TMR_ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
        default: begin
          state_d = IDLE;
          gnt_d   = 2'b00;
        end
      endcase
    end
  end

  // FSM state and every output register, decoded from the state being entered.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= TMR_ZERO;
      gnt_q   <= 2'b00;
      rr_q    <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      red_q   <= CNT_ZERO;
      blue_q  <= CNT_ZERO;
      green_q <= CNT_ZERO;
      sat_q   <= 3'b000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      gnt_q        <= gnt_d;
      rr_q         <= rr_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      s0_q         <= (state_d != IDLE);
      s1_q         <= 1'b0;
      {s2_q, s3_q} <= filter_code(state_d);
      if (latch_s) begin
        case (state_q)
          GATE_R: begin
            red_q    <= cnt_s;
            sat_q[0] <= cnt_sat_s;
          end
          GATE_B: begin
            blue_q   <= cnt_s;
            sat_q[1] <= cnt_sat_s;
          end
          GATE_G: begin
            green_q  <= cnt_s;
            sat_q[2] <= cnt_sat_s;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign gnt   = gnt_q;
  assign S0    = s0_q;
  assign S1    = s1_q;
  assign S2    = s2_q;
  assign S3    = s3_q;
  assign red   = red_q;
  assign blue  = blue_q;
  assign green = green_q;
  assign sat   = sat_q;
  assign done  = done_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_color_scan_scheduler.sv
// Self-checking bench for color_scan_scheduler: scan vectors with a result
// scoreboard, plus abort, reset, arbitration and saturation sequences.
module tb_color_scan_scheduler;

  localparam int SETTLE   = 4;
  localparam int GATE     = 100;
  localparam int GATE_SAT = 3000;
  localparam int LAT      = 2 + 3 * (SETTLE + GATE);

  logic       clk_50, rst_n;
  logic [1:0] req, gnt;
  logic       sensor_out, S0, S1, S2, S3, done, busy;
  logic [9:0] red, blue, green;
  logic [2:0] sat;

  logic [1:0] req_x, gnt_x;
  logic       sensor_x, S0_x, S1_x, S2_x, S3_x, done_x, busy_x;
  logic [9:0] red_x, blue_x, green_x;
  logic [2:0] sat_x;

  int n_checks = 0;
  int n_fail   = 0;
  int per_r    = 4;
  int per_b    = 5;
  int per_g    = 10;

  typedef struct {
    logic [1:0] req;
    int         pr, pb, pg;
    logic [1:0] gnt;
    int         er, eb, eg;
    logic [2:0] esat;
  } vec_t;

  typedef struct {
    logic [1:0] gnt;
    int         er, eb, eg;
    logic [2:0] esat;
  } exp_t;

  vec_t vecs[3];
  exp_t sb[$];

  color_scan_scheduler #(.SETTLE_CYC(SETTLE), .GATE_CYC(GATE)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .req(req), .gnt(gnt), .sensor_out(sensor_out),
    .S0(S0), .S1(S1), .S2(S2), .S3(S3), .red(red), .blue(blue), .green(green),
    .sat(sat), .done(done), .busy(busy)
  );

  color_scan_scheduler #(.SETTLE_CYC(SETTLE), .GATE_CYC(GATE_SAT)) dut_sat (
    .clk_50(clk_50), .rst_n(rst_n), .req(req_x), .gnt(gnt_x), .sensor_out(sensor_x),
    .S0(S0_x), .S1(S1_x), .S2(S2_x), .S3(S3_x), .red(red_x), .blue(blue_x),
    .green(green_x), .sat(sat_x), .done(done_x), .busy(busy_x)
  );

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  // Sensor frequency follows whichever filter the DUT currently selects.
  initial begin
    int ph;
    int cur;
    ph = 0;
    sensor_out = 1'b0;
    forever begin
      @(negedge clk_50);
      cur = S2 ? per_g : (S3 ? per_b : per_r);
      ph = (ph + 1 >= cur) ? 0 : ph + 1;
      sensor_out = (ph < cur / 2);
    end
  end

  // Fastest possible input: one rising edge every two clocks.
  initial begin
    sensor_x = 1'b0;
    forever begin
      @(negedge clk_50);
      sensor_x = ~sensor_x;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    n_checks++;
    if (act < exp - 1 || act > exp + 1) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d+-1", name, act, exp);
    end
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_gnt"}, {30'd0, gnt}, {30'd0, e.gnt});
      check_near({tag, "_red"}, int'(red), e.er);
      check_near({tag, "_blue"}, int'(blue), e.eb);
      check_near({tag, "_green"}, int'(green), e.eg);
      check({tag, "_sat"}, {29'd0, sat}, {29'd0, e.esat});
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk_50);
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic reach_gate_b();
    bit hit = 1'b0;
    for (int t = 0; t < 1000 && !hit; t++) begin
      @(negedge clk_50);
      if (busy && S3 && !S2) hit = 1'b1;
    end
    check("reach_gate_b", {31'd0, hit}, 32'd1);
    repeat (SETTLE + 30) @(negedge clk_50);
  endtask

  task automatic do_scan(input string tag, input vec_t v);
    exp_t       e;
    int         lat = 0;
    int         sbad = 0;
    bit         seen = 1'b0;
    logic [1:0] seqq[$];
    logic [5:0] seqv;
    per_r = v.pr;
    per_b = v.pb;
    per_g = v.pg;
    e.gnt = v.gnt; e.er = v.er; e.eb = v.eb; e.eg = v.eg; e.esat = v.esat;
    sb.push_back(e);
    @(negedge clk_50);
    req = v.req;
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk_50);
      if (gnt != 2'b00) lat++;
      if (busy) begin
        if (!(S0 && !S1)) sbad++;
        if (seqq.size() == 0 || seqq[$] != {S2, S3}) seqq.push_back({S2, S3});
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    compare_result(tag);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_scale_busy"}, sbad, 32'd0);
    seqv = (seqq.size() == 3) ? {seqq[0], seqq[1], seqq[2]} : 6'h3F;
    check({tag, "_filter_seq"}, {26'd0, seqv}, {26'd0, 6'b00_01_11});
    req = 2'b00;
    @(negedge clk_50);
    check({tag, "_idle_after"}, {27'd0, done, busy, gnt, S0}, 32'd0);
  endtask

  initial begin
    int dcnt;
    bit seen;

    vecs[0] = '{req: 2'b01, pr: 4,  pb: 5,  pg: 10, gnt: 2'b01, er: 25, eb: 20, eg: 10, esat: 3'b000};
    vecs[1] = '{req: 2'b10, pr: 10, pb: 4,  pg: 5,  gnt: 2'b10, er: 10, eb: 25, eg: 20, esat: 3'b000};
    vecs[2] = '{req: 2'b01, pr: 20, pb: 10, pg: 4,  gnt: 2'b01, er: 5,  eb: 10, eg: 25, esat: 3'b000};

    rst_n = 1'b0;
    req   = 2'b00;
    req_x = 2'b00;
    repeat (3) @(negedge clk_50);
    check("reset_ctrl", {21'd0, gnt, S0, S1, S2, S3, sat, done, busy}, 32'd0);
    check("reset_colour", {2'd0, red, blue, green}, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) do_scan($sformatf("vec%0d", i), vecs[i]);

    // Abort mid blue gate: red relatches, blue/green keep vec2 results.
    per_r = 4; per_b = 4; per_g = 4;
    @(negedge clk_50);
    req = 2'b01;
    reach_gate_b();
    req = 2'b00;
    @(negedge clk_50);
    check("abort_gnt_busy", {29'd0, gnt, busy}, 32'd0);
    check("abort_s0_idle", {31'd0, S0}, 32'd0);
    dcnt = 0;
    repeat (400) begin
      @(negedge clk_50);
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 32'd0);
    check_near("abort_red_new", int'(red), 25);
    check_near("abort_blue_prior", int'(blue), 10);
    check_near("abort_green_prior", int'(green), 25);

    // Asynchronous reset in the middle of the blue gate.
    per_r = 4; per_b = 5; per_g = 10;
    @(negedge clk_50);
    req = 2'b01;
    reach_gate_b();
    #5 rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {21'd0, gnt, S0, S1, S2, S3, sat, done, busy}, 32'd0);
    check("midreset_colour", {2'd0, red, blue, green}, 32'd0);
    req = 2'b00;
    dcnt = 0;
    repeat (3) begin
      @(negedge clk_50);
      if (done) dcnt++;
    end
    check("midreset_no_done", dcnt, 32'd0);
    rst_n = 1'b1;
    do_scan("post_reset", vecs[0]);

    // Tie from reset: req[0] first, req[1] next, one IDLE cycle between.
    rst_n = 1'b0;
    @(negedge clk_50);
    rst_n = 1'b1;
    per_r = 4; per_b = 5; per_g = 10;
    sb.push_back('{gnt: 2'b01, er: 25, eb: 20, eg: 10, esat: 3'b000});
    sb.push_back('{gnt: 2'b10, er: 25, eb: 20, eg: 10, esat: 3'b000});
    @(negedge clk_50);
    req = 2'b11;
    wait_done("arb1");
    compare_result("arb1");
    @(negedge clk_50);
    check("arb_idle_gap", {29'd0, gnt, busy}, 32'd0);
    @(negedge clk_50);
    check("arb_second_gnt", {30'd0, gnt}, 32'd2);
    wait_done("arb2");
    compare_result("arb2");
    req = 2'b00;
    @(negedge clk_50);

    // Saturation on the long-gate instance.
    req_x = 2'b01;
    seen = 1'b0;
    for (int t = 0; t < 12000 && !seen; t++) begin
      @(negedge clk_50);
      if (done_x === 1'b1) seen = 1'b1;
    end
    check("sat_done_seen", {31'd0, seen}, 32'd1);
    check("sat_gnt", {30'd0, gnt_x}, 32'd1);
    check("sat_red", {22'd0, red_x}, 32'd1023);
    check("sat_blue", {22'd0, blue_x}, 32'd1023);
    check("sat_green", {22'd0, green_x}, 32'd1023);
    check("sat_flags", {29'd0, sat_x}, 32'd7);
    req_x = 2'b00;
    @(negedge clk_50);
    check("sat_idle", {25'd0, S0_x, S1_x, S2_x, S3_x, busy_x, gnt_x}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
